lsu_mem_arbiter: RTL and testbench

Shares the single data-memory port between the load pipe and the store-queue drain. Retired stores leave the store queue through this block as posted writes. It generates byte enables and replicated write data from func3, and it issues at most one outstanding load. Returned load words are aligned and sign/zero-extended, and responses for flushed loads are suppressed. It sits between the LSU (load request side and store-queue retire port) and the data-memory interface.

---
 rtl/common_pkg.sv | 34 +++
 rtl/lsu_mem_arbiter_load_align.sv | 32 +++
 rtl/lsu_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared LSU definitions: ROB sizing, load/store func3 encodings, the
// memory-arbiter state type and the store byte-lane formatting helpers.
package common;

    localparam int ROB_WIDTH = 4;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    typedef enum logic {ARB_IDLE, ARB_LD_WAIT} lsu_arb_state_t;

    // Byte enables for a store of the given width at byte offset off.
    function automatic logic [3:0] st_be_gen(input logic [2:0] func3, input logic [1:0] off);
        case (func3)
            LSU_F3_B: return 4'b0001 << off;
            LSU_F3_H: return 4'b0011 << {off[1], 1'b0};
            LSU_F3_W: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

    // Replicate the LSB-aligned store data across every lane it may land in.
    function automatic logic [31:0] st_wdata_gen(input logic [2:0] func3, input logic [31:0] d);
        case (func3)
            LSU_F3_B: return {4{d[7:0]}};
            LSU_F3_H: return {2{d[15:0]}};
            default:  return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_load_align.sv
// lsu_load_align: picks the addressed byte/halfword out of a returned memory
// word and sign- or zero-extends it according to the load func3.
module lsu_load_align
    import common::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = 8'(rdata >> {off, 3'b000});
    assign sel_half = off[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane to 32 bits.
    always_comb begin
        // NOTE: default first so every path assigns data and no latch is inferred.
        data = '0;
        case (func3)
            LSU_F3_B:  data = {{24{sel_byte[7]}}, sel_byte};
            LSU_F3_H:  data = {{16{sel_half[15]}}, sel_half};
            LSU_F3_W:  data = rdata;
            LSU_F3_BU: data = {24'b0, sel_byte};
            LSU_F3_HU: data = {16'b0, sel_half};
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the data-memory port between the load pipe and the
// store-queue drain. Loads have priority and at most one is outstanding;
// stores are posted writes. Optional store starvation guard is enabled by
// defining LSU_ARB_STARVE_GUARD_EN.
module lsu_mem_arbiter
    import common::*;
#(
    parameter int LD_STARVE_MAX = 4
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ld_req_valid,
    input  logic [31:0]          ld_req_addr,
    input  logic [2:0]           ld_req_func3,
    input  logic [ROB_WIDTH:0]   ld_req_robid,
    output logic                 ld_req_ready,
    output logic                 ld_resp_valid,
    output logic [31:0]          ld_resp_data,
    output logic [ROB_WIDTH:0]   ld_resp_robid,
    input  logic                 st_valid,
    input  logic [31:0]          st_addr,
    input  logic [31:0]          st_data,
    input  logic [2:0]           st_func3,
    output logic                 st_ready,
    input  logic                 flush_valid,
    input  logic [ROB_WIDTH:0]   flush_robid,
    output logic                 mem_req_valid,
    output logic                 mem_req_we,
    output logic [31:0]          mem_req_addr,
    output logic [31:0]          mem_req_wdata,
    output logic [3:0]           mem_req_be,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_rdata
);

    localparam int W = ROB_WIDTH;

    if (LD_STARVE_MAX < 1 || LD_STARVE_MAX > 15) begin : g_bad_starve_max
        $error("LD_STARVE_MAX must be in 1..15");
    end

    lsu_arb_state_t state;
    logic [W:0]     rid;
    logic [2:0]     rf3;
    logic [1:0]     roff;
    logic           killed;

    logic           ld_elig;
    logic           store_wins;
    logic           sel_ld;
    logic           sel_st;
    logic           flush_hit;
    logic [31:0]    aligned;

`ifdef LSU_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign store_wins = st_valid && (starve_cnt >= 4'(LD_STARVE_MAX));

    // Count load grants that overtook a waiting store; any store grant or an
    // empty store queue restarts the count.
    always_ff @(posedge clk) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (st_ready || !st_valid)
            starve_cnt <= '0;
        else if (ld_req_ready && starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    assign store_wins = 1'b0;
`endif

    // A load arriving alongside a flush may be the flushed one, so it waits.
    assign ld_elig = ld_req_valid && !flush_valid;

    // NOTE: reset is synchronous, so the request side is gated with reset_n to
    // keep the memory port quiet while the state register still holds LD_WAIT.
    assign sel_ld = reset_n && (state == ARB_IDLE) && ld_elig && !store_wins;
    assign sel_st = reset_n && (state == ARB_IDLE) && st_valid && !sel_ld;

    assign mem_req_valid = sel_ld || sel_st;
    assign mem_req_we    = sel_st;
    assign mem_req_addr  = sel_ld ? {ld_req_addr[31:2], 2'b00} : {st_addr[31:2], 2'b00};
    assign mem_req_wdata = st_wdata_gen(st_func3, st_data);
    assign mem_req_be    = sel_st ? st_be_gen(st_func3, st_addr[1:0]) : 4'b0000;

    assign ld_req_ready  = sel_ld && mem_req_ready;
    assign st_ready      = sel_st && mem_req_ready;

    // Outstanding load is younger than the flush point (wrap-bit aware compare).
    assign flush_hit = flush_valid &&
                       (flush_robid[W] ^ rid[W] ^ (rid[W-1:0] > flush_robid[W-1:0]));

    lsu_load_align u_align (
        .rdata (mem_resp_rdata),
        .func3 (rf3),
        .off   (roff),
        .data  (aligned)
    );

    // Arbiter FSM: track the single outstanding load and register its response.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            state         <= ARB_IDLE;
            rid           <= '0;
            rf3           <= '0;
            roff          <= '0;
            killed        <= 1'b0;
            ld_resp_valid <= 1'b0;
            ld_resp_data  <= '0;
            ld_resp_robid <= '0;
        end else begin
            ld_resp_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (ld_req_ready) begin
                        state  <= ARB_LD_WAIT;
                        rid    <= ld_req_robid;
                        rf3    <= ld_req_func3;
                        roff   <= ld_req_addr[1:0];
                        killed <= 1'b0;
                    end
                end
                ARB_LD_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= ARB_IDLE;
                        if (!(killed || flush_hit)) begin
                            ld_resp_valid <= 1'b1;
                            ld_resp_data  <= aligned;
                            ld_resp_robid <= rid;
                        end
                    end else if (flush_hit) begin
                        killed <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed, table-driven bench for lsu_mem_arbiter (built with LD_STARVE_MAX=2;
// the starvation sequence adapts to LSU_ARB_STARVE_GUARD_EN).
module tb_lsu_mem_arbiter;
    import common::*;

    localparam int RW = ROB_WIDTH + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ld_req_valid;
    logic [31:0]   ld_req_addr;
    logic [2:0]    ld_req_func3;
    logic [RW-1:0] ld_req_robid;
    logic          ld_req_ready;
    logic          ld_resp_valid;
    logic [31:0]   ld_resp_data;
    logic [RW-1:0] ld_resp_robid;
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_func3;
    logic          st_ready;
    logic          flush_valid;
    logic [RW-1:0] flush_robid;
    logic          mem_req_valid;
    logic          mem_req_we;
    logic [31:0]   mem_req_addr;
    logic [31:0]   mem_req_wdata;
    logic [3:0]    mem_req_be;
    logic          mem_req_ready;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_rdata;

    always #5 clk = ~clk;

    lsu_mem_arbiter #(.LD_STARVE_MAX(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ld_req_valid   (ld_req_valid),
        .ld_req_addr    (ld_req_addr),
        .ld_req_func3   (ld_req_func3),
        .ld_req_robid   (ld_req_robid),
        .ld_req_ready   (ld_req_ready),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .ld_resp_robid  (ld_resp_robid),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_func3       (st_func3),
        .st_ready       (st_ready),
        .flush_valid    (flush_valid),
        .flush_robid    (flush_robid),
        .mem_req_valid  (mem_req_valid),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_be     (mem_req_be),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_wd;
    } st_vec_t;

    typedef struct {
        logic [2:0]    f3;
        logic [31:0]   addr;
        logic [31:0]   rdata;
        logic [RW-1:0] robid;
        logic [31:0]   exp;
    } ld_vec_t;

    st_vec_t sv[6];
    ld_vec_t lv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_req_valid   = 1'b0;
        ld_req_addr    = '0;
        ld_req_func3   = '0;
        ld_req_robid   = '0;
        st_valid       = 1'b0;
        st_addr        = '0;
        st_data        = '0;
        st_func3       = '0;
        flush_valid    = 1'b0;
        flush_robid    = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    // One load with a 2-cycle memory latency; flush_at 1 = flush in the idle
    // wait cycle, 2 = flush in the response cycle, 0 = no flush.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [RW-1:0] robid,
                            input int flush_at, input logic [RW-1:0] frob,
                            input logic exp_valid, input logic [31:0] exp_data);
        ld_req_valid  = 1'b1;
        ld_req_func3  = f3;
        ld_req_addr   = addr;
        ld_req_robid  = robid;
        mem_req_ready = 1'b1;
        #1;
        check({tag, " req_valid"}, 32'(mem_req_valid), 32'd1);
        check({tag, " req_we"},    32'(mem_req_we),    32'd0);
        check({tag, " req_addr"},  mem_req_addr,       {addr[31:2], 2'b00});
        check({tag, " ld_ready"},  32'(ld_req_ready),  32'd1);
        tick();
        ld_req_valid = 1'b0;
        if (flush_at == 1) begin
            flush_valid = 1'b1;
            flush_robid = frob;
        end
        #1;
        check({tag, " wait_quiet"}, 32'(mem_req_valid), 32'd0);
        tick();
        flush_valid    = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        if (flush_at == 2) begin
            flush_valid = 1'b1;
            flush_robid = frob;
        end
        tick();
        mem_resp_valid = 1'b0;
        flush_valid    = 1'b0;
        check({tag, " resp_valid"}, 32'(ld_resp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check({tag, " resp_data"},  ld_resp_data,         exp_data);
            check({tag, " resp_robid"}, 32'(ld_resp_robid),   32'(robid));
        end
    endtask

    initial begin
        logic guard_on;
`ifdef LSU_ARB_STARVE_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif

        sv[0] = '{LSU_F3_B, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 1'b1};
        sv[1] = '{LSU_F3_H, 32'h0000_1002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 1'b1};
        sv[2] = '{LSU_F3_H, 32'h0000_1001, 32'h0000_1234, 4'b0011, 32'h1234_1234, 1'b1};
        sv[3] = '{LSU_F3_W, 32'h0000_2006, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b1};
        sv[4] = '{LSU_F3_B, 32'h0000_2000, 32'h0000_0055, 4'b0001, 32'h5555_5555, 1'b1};
        sv[5] = '{3'b011,   32'h0000_3000, 32'h1122_3344, 4'b0000, 32'h0,        1'b0};

        lv[0] = '{LSU_F3_B,  32'h0000_2001, 32'h0000_80FF, 5'd1, 32'hFFFF_FF80};
        lv[1] = '{LSU_F3_BU, 32'h0000_2001, 32'h0000_80FF, 5'd2, 32'h0000_0080};
        lv[2] = '{LSU_F3_H,  32'h0000_2002, 32'h8001_1234, 5'd3, 32'hFFFF_8001};
        lv[3] = '{LSU_F3_HU, 32'h0000_2002, 32'h8001_1234, 5'd4, 32'h0000_8001};
        lv[4] = '{LSU_F3_W,  32'h0000_2004, 32'hCAFE_F00D, 5'd5, 32'hCAFE_F00D};
        lv[5] = '{LSU_F3_H,  32'h0000_2000, 32'h8001_7FFE, 5'd6, 32'h0000_7FFE};
        lv[6] = '{LSU_F3_B,  32'h0000_2003, 32'h7F00_0000, 5'd7, 32'h0000_007F};
        lv[7] = '{LSU_F3_BU, 32'h0000_2000, 32'h0000_00F0, 5'd17, 32'h0000_00F0};

        // Reset with both requesters active: the memory port must stay quiet.
        idle_inputs();
        reset_n      = 1'b0;
        ld_req_valid = 1'b1;
        st_valid     = 1'b1;
        tick();
        tick();
        check("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst ld_req_ready",  32'(ld_req_ready),  32'd0);
        check("rst st_ready",      32'(st_ready),      32'd0);
        check("rst ld_resp_valid", 32'(ld_resp_valid), 32'd0);
        check("rst ld_resp_data",  ld_resp_data,       32'd0);
        check("rst ld_resp_robid", 32'(ld_resp_robid), 32'd0);
        idle_inputs();
        reset_n = 1'b1;
        tick();
        check("idle mem_req_valid", 32'(mem_req_valid), 32'd0);

        // Stray memory response in IDLE is ignored.
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        check("stray resp", 32'(ld_resp_valid), 32'd0);

        // Store formatting table.
        for (int i = 0; i < 6; i++) begin
            st_valid = 1'b1;
            st_func3 = sv[i].f3;
            st_addr  = sv[i].addr;
            st_data  = sv[i].d;
            #1;
            check($sformatf("st%0d valid", i),    32'(mem_req_valid), 32'd1);
            check($sformatf("st%0d we", i),       32'(mem_req_we),    32'd1);
            check($sformatf("st%0d addr", i),     mem_req_addr,       {sv[i].addr[31:2], 2'b00});
            check($sformatf("st%0d be", i),       32'(mem_req_be),    32'(sv[i].be));
            check($sformatf("st%0d st_ready", i), 32'(st_ready),      32'd1);
            check($sformatf("st%0d ld_ready", i), 32'(ld_req_ready),  32'd0);
            if (sv[i].chk_wd)
                check($sformatf("st%0d wdata", i), mem_req_wdata, sv[i].wd);
            tick();
        end
        st_valid = 1'b0;

        // Store held off by memory back-pressure.
        st_valid      = 1'b1;
        st_func3      = LSU_F3_W;
        st_addr       = 32'h0000_4000;
        mem_req_ready = 1'b0;
        #1;
        check("st bp valid",    32'(mem_req_valid), 32'd1);
        check("st bp st_ready", 32'(st_ready),      32'd0);
        tick();
        st_valid      = 1'b0;
        mem_req_ready = 1'b1;

        // Load alignment table.
        for (int i = 0; i < 8; i++)
            run_load($sformatf("ld%0d", i), lv[i].f3, lv[i].addr, lv[i].rdata, lv[i].robid,
                     0, '0, 1'b1, lv[i].exp);

        // Load held off by back-pressure stays in IDLE and keeps requesting.
        ld_req_valid  = 1'b1;
        ld_req_func3  = LSU_F3_W;
        ld_req_addr   = 32'h0000_5000;
        mem_req_ready = 1'b0;
        #1;
        check("ld bp ld_ready", 32'(ld_req_ready), 32'd0);
        tick();
        check("ld bp still req", 32'(mem_req_valid), 32'd1);
        ld_req_valid  = 1'b0;
        mem_req_ready = 1'b1;

        // A load is not eligible in a flush cycle.
        ld_req_valid = 1'b1;
        flush_valid  = 1'b1;
        #1;
        check("flush blocks ld", 32'(mem_req_valid), 32'd0);
        tick();
        ld_req_valid = 1'b0;
        flush_valid  = 1'b0;

        // Flush hits the outstanding load (robid 5, flush point 3): suppressed.
        run_load("fl_kill", LSU_F3_W, 32'h0000_6000, 32'hAAAA_5555, 5'd5, 1, 5'd3, 1'b0, 32'h0);
        // Next load is accepted and delivered (killed flag cleared).
        run_load("fl_next", LSU_F3_W, 32'h0000_6004, 32'h0BAD_CAFE, 5'd6, 0, '0, 1'b1, 32'h0BAD_CAFE);
        // Older load (robid 7 vs flush point 8) survives a same-cycle flush.
        run_load("fl_old", LSU_F3_LBU_DUMMY_FIX(), 32'h0000_6001, 32'h0000_4200, 5'd7, 2, 5'd8, 1'b1, 32'h0000_0042);
        // Same-cycle flush that hits (robid 7 vs flush point 2).
        run_load("fl_same", LSU_F3_W, 32'h0000_6008, 32'h1111_2222, 5'd7, 2, 5'd2, 1'b0, 32'h0);
        // Wrapped robid 0_0001 is younger than flush point 1_1110.
        run_load("fl_wrap", LSU_F3_W, 32'h0000_600C, 32'h3333_4444, 5'b00001, 1, 5'b11110, 1'b0, 32'h0);

        // Load beats a waiting store; the store drains once the load returns.
        ld_req_valid = 1'b1;
        ld_req_func3 = LSU_F3_W;
        ld_req_addr  = 32'h0000_7000;
        ld_req_robid = 5'd9;
        st_valid     = 1'b1;
        st_func3     = LSU_F3_W;
        st_addr      = 32'h0000_8000;
        st_data      = 32'h0F0F_0F0F;
        #1;
        check("prio ld_ready", 32'(ld_req_ready), 32'd1);
        check("prio st_ready", 32'(st_ready),     32'd0);
        check("prio we",       32'(mem_req_we),   32'd0);
        tick();
        ld_req_valid = 1'b0;
        #1;
        check("prio wait st_ready", 32'(st_ready), 32'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h7777_7777;
        #1;
        check("prio resp st_ready", 32'(st_ready), 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        check("prio ld_resp_valid", 32'(ld_resp_valid), 32'd1);
        check("prio st_ready after", 32'(st_ready),     32'd1);
        tick();
        st_valid = 1'b0;
        tick();

        // Continuous loads with a pending store: with the guard the store wins
        // the third arbitration, then the cleared counter lets loads win again.
        ld_req_valid = 1'b1;
        ld_req_func3 = LSU_F3_W;
        ld_req_addr  = 32'h0000_9000;
        st_valid     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_st;
            exp_st = guard_on && (k == 2);
            ld_req_robid = 5'(k);
            #1;
            check($sformatf("starve%0d st_ready", k), 32'(st_ready),     32'(exp_st));
            check($sformatf("starve%0d ld_ready", k), 32'(ld_req_ready), 32'(!exp_st));
            if (exp_st) begin
                tick();
            end else begin
                tick();
                tick();
                mem_resp_valid = 1'b1;
                tick();
                mem_resp_valid = 1'b0;
            end
        end
        idle_inputs();
        tick();

        // Reset in LD_WAIT drops the load; the late response is ignored.
        ld_req_valid = 1'b1;
        ld_req_func3 = LSU_F3_W;
        ld_req_addr  = 32'h0000_A000;
        ld_req_robid = 5'd3;
        tick();
        ld_req_valid = 1'b0;
        reset_n      = 1'b0;
        tick();
        reset_n        = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5A5A_5A5A;
        tick();
        mem_resp_valid = 1'b0;
        check("rst mid late resp", 32'(ld_resp_valid), 32'd0);
        run_load("rst recover", LSU_F3_W, 32'h0000_A004, 32'h2468_ACE0, 5'd4, 0, '0, 1'b1, 32'h2468_ACE0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [2:0] LSU_F3_LBU_DUMMY_FIX();
        return LSU_F3_BU;
    endfunction

endmodule
